// File: rtl/mem_access_unit.sv
// RV32 load/store initiator for a word-wide DataMem without byte enables: word-aligns, extends loads,
// read-modify-writes sub-word stores. SW/errors 2 cycles, loads 3, SB/SH 4; start ignored while busy.
module mem_access_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            isStore,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] storeData,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] loadData,
  output logic            misaligned,
  output logic            accessFault,
  output logic [XLEN-1:0] memAddress,
  output logic [XLEN-1:0] memWriteData,
  output logic            memWriteEnable,
  output logic            memReadEnable,
  input  logic [XLEN-1:0] memReadData
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_REQ, S_RD_WAIT, S_WR, S_ERR, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic            is_store_q, is_store_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] store_data_q, store_data_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            misaligned_q, misaligned_d;
  logic            access_fault_q, access_fault_d;
  logic [XLEN-1:0] load_data_q, load_data_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
  logic            mem_we_q, mem_we_d;
  logic            mem_re_q, mem_re_d;

  logic            req_illegal, req_misaligned;
  logic [4:0]      byte_sh, half_sh;
  logic [XLEN-1:0] rd_byte_w, rd_half_w, load_ext, lane_mask, lane_ins, merged;
  logic [7:0]      rd_byte;
  logic [15:0]     rd_half;

  // Request checks use the live inputs because they are only acted on in IDLE.
  always_comb begin
    req_illegal    = isStore ? (funct3[2] | (funct3 == 3'b011))
                             : ((funct3 == 3'b011) | (funct3 == 3'b110) | (funct3 == 3'b111));
    req_misaligned = ((funct3[1:0] == 2'b01) & addr[0]) |
                     ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
  end

  always_comb begin
    byte_sh   = {addr_q[1:0], 3'b000};
    half_sh   = {addr_q[1], 4'b0000};
    rd_byte_w = memReadData >> byte_sh;
    rd_half_w = memReadData >> half_sh;
    rd_byte   = rd_byte_w[7:0];
    rd_half   = rd_half_w[15:0];
    case (funct3_q)
      3'b000:  load_ext = {{(XLEN-8){rd_byte[7]}}, rd_byte};
      3'b100:  load_ext = {{(XLEN-8){1'b0}}, rd_byte};
      3'b001:  load_ext = {{(XLEN-16){rd_half[15]}}, rd_half};
      3'b101:  load_ext = {{(XLEN-16){1'b0}}, rd_half};
      default: load_ext = memReadData;
    endcase
    if (funct3_q[1:0] == 2'b00) begin
      lane_mask = XLEN'(8'hFF) << byte_sh;
      lane_ins  = XLEN'(store_data_q[7:0]) << byte_sh;
    end else begin
      lane_mask = XLEN'(16'hFFFF) << half_sh;
      lane_ins  = XLEN'(store_data_q[15:0]) << half_sh;
    end
    merged = (memReadData & ~lane_mask) | lane_ins;
  end

  // Outputs are registered from the next state, so strobes line up with the state they belong to.
  always_comb begin
    state_d        = state_q;
    is_store_d     = is_store_q;
    funct3_d       = funct3_q;
    addr_d         = addr_q;
    store_data_d   = store_data_q;
    misaligned_d   = misaligned_q;
    access_fault_d = access_fault_q;
    load_data_d    = load_data_q;
    done_d         = 1'b0;
    mem_we_d       = 1'b0;
    mem_re_d       = 1'b0;
    mem_addr_d     = '0;
    mem_wdata_d    = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          is_store_d   = isStore;
          funct3_d     = funct3;
          addr_d       = addr;
          store_data_d = storeData;
          if (req_illegal) begin
            access_fault_d = 1'b1;
            state_d        = S_ERR;
          end else if (req_misaligned) begin
            misaligned_d = 1'b1;
            state_d      = S_ERR;
          end else if (isStore && funct3 == 3'b010) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = {addr[XLEN-1:2], 2'b00};
            mem_wdata_d = storeData;
            state_d     = S_WR;
          end else begin
            mem_re_d   = 1'b1;
            mem_addr_d = {addr[XLEN-1:2], 2'b00};
            state_d    = S_RD_REQ;
          end
        end
      end
      S_RD_REQ: state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        if (is_store_q) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = {addr_q[XLEN-1:2], 2'b00};
          mem_wdata_d = merged;
          state_d     = S_WR;
        end else begin
          load_data_d = load_ext;
          done_d      = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_WR, S_ERR: begin
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        misaligned_d   = 1'b0;
        access_fault_d = 1'b0;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      is_store_q     <= 1'b0;
      funct3_q       <= '0;
      addr_q         <= '0;
      store_data_q   <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      misaligned_q   <= 1'b0;
      access_fault_q <= 1'b0;
      load_data_q    <= '0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      mem_we_q       <= 1'b0;
      mem_re_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      is_store_q     <= is_store_d;
      funct3_q       <= funct3_d;
      addr_q         <= addr_d;
      store_data_q   <= store_data_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      misaligned_q   <= misaligned_d;
      access_fault_q <= access_fault_d;
      load_data_q    <= load_data_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      mem_we_q       <= mem_we_d;
      mem_re_q       <= mem_re_d;
    end
  end

  // Strobes are masked by reset directly so a write in flight cannot land while reset is high.
  assign memWriteEnable = mem_we_q & ~reset;
  assign memReadEnable  = mem_re_q & ~reset;
  assign memAddress     = (memWriteEnable | memReadEnable) ? mem_addr_q : '0;
  assign memWriteData   = mem_wdata_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign loadData       = load_data_q;
  assign misaligned     = misaligned_q;
  assign accessFault    = access_fault_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: word memory model on the DataMem side, byte-level reference model for expectations.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        isStore = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] storeData = 32'd0;
  logic        busy, done, misaligned, accessFault, memWriteEnable, memReadEnable;
  logic [31:0] loadData, memAddress, memWriteData;
  logic [31:0] memReadData = 32'd0;

  mem_access_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .isStore(isStore), .funct3(funct3),
    .addr(addr), .storeData(storeData), .busy(busy), .done(done), .loadData(loadData),
    .misaligned(misaligned), .accessFault(accessFault), .memAddress(memAddress),
    .memWriteData(memWriteData), .memWriteEnable(memWriteEnable),
    .memReadEnable(memReadEnable), .memReadData(memReadData)
  );

  always #5 clk = ~clk;

  // DataMem stand-in: 256 words, aliased on address bits [9:2]
  logic [31:0] mem [0:255];
  int          rd_total = 0;
  int          wr_total = 0;
  logic [31:0] last_mem_addr = 32'd0;

  always @(posedge clk) begin
    if (memReadEnable) begin
      memReadData   <= mem[memAddress[9:2]];
      rd_total      = rd_total + 1;
      last_mem_addr = memAddress;
    end
    if (memWriteEnable) begin
      mem[memAddress[9:2]] = memWriteData;
      wr_total      = wr_total + 1;
      last_mem_addr = memAddress;
    end
  end

  // Reference model state: byte-addressed memory and expected results
  logic [7:0]  ref_bytes [0:1023];
  logic [31:0] exp_load = 32'd0;
  logic        exp_mis, exp_fault;
  int          exp_cyc, exp_rd, exp_wr;

  int          total = 0;
  int          bad = 0;

  int          obs_cyc, obs_rd, obs_wr;
  logic [31:0] obs_load;
  logic        obs_mis, obs_fault, obs_busy_bad, obs_addr_bad;
  logic [1:0]  obs_after;

  task automatic init_word(input int idx, input logic [31:0] w);
    mem[idx] = w;
    for (int i = 0; i < 4; i++) ref_bytes[idx*4+i] = w[8*i +: 8];
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = ref_bytes[{a[9:2], 2'b00} + 10'(i)];
    return w;
  endfunction

  task automatic model_op(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd);
    int w, base;
    logic [63:0] v;
    exp_fault = st ? (f3[2] || f3 == 3'd3) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    w = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    base = int'(a[9:0]);
    exp_mis = !exp_fault && (base % w != 0);
    if (exp_fault || exp_mis) begin
      exp_cyc = 2; exp_rd = 0; exp_wr = 0;
    end else if (!st) begin
      v = 64'd0;
      for (int i = 0; i < w; i++) v = v | (64'(ref_bytes[base+i]) << (8*i));
      if (!f3[2] && w < 4 && v[8*w-1]) v = v | ~((64'd1 << (8*w)) - 64'd1);
      exp_load = v[31:0];
      exp_cyc = 3; exp_rd = 1; exp_wr = 0;
    end else begin
      for (int i = 0; i < w; i++) ref_bytes[base+i] = sd[8*i +: 8];
      exp_cyc = (w == 4) ? 2 : 4;
      exp_rd  = (w == 4) ? 0 : 1;
      exp_wr  = 1;
    end
  endtask

  // Issue one request and record what the DUT does; cycle 1 is the cycle after the accepting edge.
  task automatic do_op(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd);
    int r0, w0;
    @(negedge clk);
    isStore = st; funct3 = f3; addr = a; storeData = sd; start = 1'b1;
    r0 = rd_total; w0 = wr_total;
    obs_cyc = 0; obs_busy_bad = 1'b0; obs_addr_bad = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (!busy) obs_busy_bad = 1'b1;
      if (!memReadEnable && !memWriteEnable && memAddress != 32'd0) obs_addr_bad = 1'b1;
      if (done) begin
        obs_cyc = c; obs_load = loadData; obs_mis = misaligned; obs_fault = accessFault;
        break;
      end
    end
    @(negedge clk);
    obs_after = {done, busy};
    obs_rd = rd_total - r0;
    obs_wr = wr_total - w0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++; if ({busy, done, misaligned, accessFault, memWriteEnable, memReadEnable} !== 6'd0) begin
      bad++; $display("FAIL reset_flags got %b exp 000000", {busy, done, misaligned, accessFault, memWriteEnable, memReadEnable}); end
    total++; if (loadData !== 32'd0) begin bad++; $display("FAIL reset_loadData got %h exp 0", loadData); end
    total++; if (memAddress !== 32'd0) begin bad++; $display("FAIL reset_memAddress got %h exp 0", memAddress); end
    total++; if (memWriteData !== 32'd0) begin bad++; $display("FAIL reset_memWriteData got %h exp 0", memWriteData); end
    reset = 1'b0;
    exp_load = 32'd0;
    @(negedge clk);
    total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL idle_after_reset got %b exp 00", {busy, done}); end
  endtask

  task automatic test_spec_loads;
    logic [2:0]  f3s  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [31:0] ads  [5] = '{32'h103, 32'h103, 32'h102, 32'h100, 32'h100};
    logic [31:0] exps [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8081, 32'h0000_7F02, 32'h8081_7F02};
    init_word(32'h100 >> 2, 32'h8081_7F02);
    for (int i = 0; i < 5; i++) begin
      model_op(1'b0, f3s[i], ads[i], 32'd0);
      do_op(1'b0, f3s[i], ads[i], 32'd0);
      total++; if (obs_load !== exps[i]) begin bad++; $display("FAIL load%0d_data got %h exp %h", i, obs_load, exps[i]); end
      total++; if (obs_cyc !== 3) begin bad++; $display("FAIL load%0d_latency got %0d exp 3", i, obs_cyc); end
      total++; if (obs_rd !== 1 || obs_wr !== 0) begin bad++; $display("FAIL load%0d_accesses got rd=%0d wr=%0d exp rd=1 wr=0", i, obs_rd, obs_wr); end
    end
  endtask

  task automatic test_spec_stores;
    init_word(32'h104 >> 2, 32'h1122_3344);
    model_op(1'b1, 3'b000, 32'h105, 32'h0000_00AB);
    do_op(1'b1, 3'b000, 32'h105, 32'h0000_00AB);
    total++; if (mem[32'h104 >> 2] !== 32'h1122_AB44) begin bad++; $display("FAIL sb_mem got %h exp 1122ab44", mem[32'h104 >> 2]); end
    total++; if (obs_cyc !== 4) begin bad++; $display("FAIL sb_latency got %0d exp 4", obs_cyc); end
    total++; if (obs_rd !== 1 || obs_wr !== 1) begin bad++; $display("FAIL sb_accesses got rd=%0d wr=%0d exp 1/1", obs_rd, obs_wr); end
    model_op(1'b1, 3'b001, 32'h106, 32'h1234_BEEF);
    do_op(1'b1, 3'b001, 32'h106, 32'h1234_BEEF);
    total++; if (mem[32'h104 >> 2] !== 32'hBEEF_AB44) begin bad++; $display("FAIL sh_mem got %h exp beefab44", mem[32'h104 >> 2]); end
    total++; if (obs_cyc !== 4) begin bad++; $display("FAIL sh_latency got %0d exp 4", obs_cyc); end
    model_op(1'b1, 3'b010, 32'h200, 32'hDEAD_BEEF);
    do_op(1'b1, 3'b010, 32'h200, 32'hDEAD_BEEF);
    total++; if (mem[32'h200 >> 2] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL sw_mem got %h exp deadbeef", mem[32'h200 >> 2]); end
    total++; if (obs_cyc !== 2) begin bad++; $display("FAIL sw_latency got %0d exp 2", obs_cyc); end
    total++; if (obs_rd !== 0 || obs_wr !== 1) begin bad++; $display("FAIL sw_accesses got rd=%0d wr=%0d exp 0/1", obs_rd, obs_wr); end
    total++; if (loadData !== 32'h8081_7F02) begin bad++; $display("FAIL store_keeps_loadData got %h exp 80817f02", loadData); end
  endtask

  task automatic test_errors;
    logic        sts  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [2:0]  f3s  [4] = '{3'b010, 3'b011, 3'b100, 3'b011};
    logic [31:0] ads  [4] = '{32'h102, 32'h100, 32'h100, 32'h101};
    logic [1:0]  flag [4] = '{2'b10, 2'b01, 2'b01, 2'b01};
    for (int i = 0; i < 4; i++) begin
      model_op(sts[i], f3s[i], ads[i], 32'hFFFF_FFFF);
      do_op(sts[i], f3s[i], ads[i], 32'hFFFF_FFFF);
      total++; if ({obs_mis, obs_fault} !== flag[i]) begin bad++; $display("FAIL err%0d_flags got mis/fault=%b exp %b", i, {obs_mis, obs_fault}, flag[i]); end
      total++; if (obs_cyc !== 2) begin bad++; $display("FAIL err%0d_latency got %0d exp 2", i, obs_cyc); end
      total++; if (obs_rd !== 0 || obs_wr !== 0) begin bad++; $display("FAIL err%0d_accesses got rd=%0d wr=%0d exp 0/0", i, obs_rd, obs_wr); end
      total++; if (obs_load !== 32'h8081_7F02) begin bad++; $display("FAIL err%0d_loadData got %h exp 80817f02", i, obs_load); end
      total++; if ({misaligned, accessFault} !== 2'b00) begin bad++; $display("FAIL err%0d_flags_clear got %b exp 00", i, {misaligned, accessFault}); end
    end
  endtask

  task automatic test_reset_mid;
    int w0, dones;
    init_word(32'h300 >> 2, 32'h0A0B_0C0D);
    w0 = wr_total;
    @(negedge clk);
    isStore = 1'b1; funct3 = 3'b000; addr = 32'h301; storeData = 32'h0000_0055; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (memWriteEnable !== 1'b1) begin bad++; $display("FAIL midreset_wr_cycle got we=%b exp 1", memWriteEnable); end
    reset = 1'b1;
    #1;
    total++; if (memWriteEnable !== 1'b0 || memAddress !== 32'd0) begin
      bad++; $display("FAIL midreset_strobe got we=%b addr=%h exp 0/0", memWriteEnable, memAddress); end
    @(negedge clk);
    reset = 1'b0;
    exp_load = 32'd0;
    dones = 0;
    repeat (6) begin @(negedge clk); if (done) dones++; end
    total++; if (dones !== 0) begin bad++; $display("FAIL midreset_no_done got %0d exp 0", dones); end
    total++; if (mem[32'h300 >> 2] !== 32'h0A0B_0C0D || wr_total != w0) begin
      bad++; $display("FAIL midreset_mem got %h writes=%0d exp 0a0b0c0d writes=0", mem[32'h300 >> 2], wr_total - w0); end
    model_op(1'b0, 3'b010, 32'h300, 32'd0);
    do_op(1'b0, 3'b010, 32'h300, 32'd0);
    total++; if (obs_load !== 32'h0A0B_0C0D || obs_cyc !== 3) begin
      bad++; $display("FAIL midreset_next_op got %h cyc=%0d exp 0a0b0c0d cyc=3", obs_load, obs_cyc); end
  endtask

  task automatic test_busy_ignore;
    int dones, done_at, w0;
    w0 = wr_total; dones = 0; done_at = 0;
    model_op(1'b0, 3'b010, 32'h100, 32'd0);
    @(negedge clk);
    isStore = 1'b0; funct3 = 3'b010; addr = 32'h100; start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (done) begin dones++; done_at = c; end
      if (c == 1) begin isStore = 1'b1; funct3 = 3'b010; addr = 32'h100; storeData = 32'h0; end
      if (c == 2) begin isStore = 1'b0; funct3 = 3'b000; addr = 32'h104; end
      if (c == 3) start = 1'b0;
    end
    total++; if (dones !== 1 || done_at !== 3) begin bad++; $display("FAIL busy_ignore_done got %0d at %0d exp 1 at 3", dones, done_at); end
    total++; if (wr_total != w0 || loadData !== exp_load) begin
      bad++; $display("FAIL busy_ignore_result got writes=%0d load=%h exp 0 %h", wr_total - w0, loadData, exp_load); end
  endtask

  task automatic test_random;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a, sd;
    for (int n = 0; n < 200; n++) begin
      st = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
      sd = $urandom;
      model_op(st, f3, a, sd);
      do_op(st, f3, a, sd);
      total++; if (obs_cyc !== exp_cyc) begin bad++; $display("FAIL rnd%0d_latency got %0d exp %0d", n, obs_cyc, exp_cyc); end
      total++; if (obs_load !== exp_load) begin bad++; $display("FAIL rnd%0d_loadData got %h exp %h", n, obs_load, exp_load); end
      total++; if ({obs_mis, obs_fault} !== {exp_mis, exp_fault}) begin
        bad++; $display("FAIL rnd%0d_flags got %b exp %b", n, {obs_mis, obs_fault}, {exp_mis, exp_fault}); end
      total++; if (obs_rd !== exp_rd || obs_wr !== exp_wr) begin
        bad++; $display("FAIL rnd%0d_accesses got rd=%0d wr=%0d exp rd=%0d wr=%0d", n, obs_rd, obs_wr, exp_rd, exp_wr); end
      total++; if (obs_busy_bad !== 1'b0 || obs_addr_bad !== 1'b0 || obs_after !== 2'b00) begin
        bad++; $display("FAIL rnd%0d_handshake got busy_bad=%b addr_bad=%b after=%b exp 0 0 00", n, obs_busy_bad, obs_addr_bad, obs_after); end
      if (exp_rd + exp_wr > 0) begin
        total++; if (last_mem_addr !== {a[31:2], 2'b00}) begin
          bad++; $display("FAIL rnd%0d_memAddress got %h exp %h", n, last_mem_addr, {a[31:2], 2'b00}); end
      end
      if (exp_wr > 0) begin
        total++; if (mem[a[9:2]] !== ref_word(a)) begin
          bad++; $display("FAIL rnd%0d_mem got %h exp %h", n, mem[a[9:2]], ref_word(a)); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) init_word(i, $urandom);
    test_reset;
    test_spec_loads;
    test_spec_stores;
    test_errors;
    test_reset_mid;
    test_busy_ignore;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
